// File: rtl/freq_gate_counter.sv
// rtl/freq_gate_counter.sv - counts edge pulses over a GATE_CYCLES window and publishes the count on a valid/ready port
// Optional FREQ_CNT_SAT_EN: saturating edge counter with per-gate sticky overflow reported on freq_ovf.
module freq_gate_counter #(
  parameter longint unsigned GATE_CYCLES = 50000000,
  parameter int unsigned     CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             edge_pulse,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic [CNT_W-1:0] freq_count,
  output logic             freq_valid,
  input  logic             freq_ready,
  output logic             freq_lost,
  output logic             freq_ovf
);

  localparam int TW = $clog2(GATE_CYCLES + 1);
  localparam logic [TW-1:0] LAST = TW'(GATE_CYCLES - 1);

  typedef enum logic {IDLE, GATE} state_t;

  state_t           state;
  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             gate_end;

  assign gate_end = (state == GATE) && (timer == LAST);

`ifdef FREQ_CNT_SAT_EN
  logic ovf_acc;
  logic ovf_next;

  always_comb begin
    cnt_next = cnt;
    ovf_next = ovf_acc;
    if (edge_pulse) begin
      if (&cnt) ovf_next = 1'b1;
      else      cnt_next = cnt + CNT_W'(1);
    end
  end

  // Sticky bit lives only for one gate; it is handed to freq_ovf together with the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_acc  <= 1'b0;
      freq_ovf <= 1'b0;
    end else if (state == IDLE) begin
      ovf_acc <= 1'b0;
    end else if (gate_end) begin
      freq_ovf <= ovf_next;
      ovf_acc  <= 1'b0;
    end else begin
      ovf_acc <= ovf_next;
    end
  end
`else
  assign cnt_next = cnt + CNT_W'(edge_pulse);
  assign freq_ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      timer      <= '0;
      cnt        <= '0;
      freq_count <= '0;
      freq_valid <= 1'b0;
      freq_lost  <= 1'b0;
    end else begin
      freq_lost <= 1'b0;
      if (freq_valid && freq_ready) freq_valid <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          cnt   <= '0;
          if (start || cont) begin
            state <= GATE;
            busy  <= 1'b1;
          end
        end
        GATE: begin
          if (gate_end) begin
            // A load overrides a same-cycle accept, so the new result stays valid.
            freq_count <= cnt_next;
            freq_valid <= 1'b1;
            freq_lost  <= freq_valid && !freq_ready;
            timer      <= '0;
            cnt        <= '0;
            if (!cont) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer + TW'(1);
            cnt   <= cnt_next;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_gate_counter.sv
// tb/tb_freq_gate_counter.sv - scoreboard bench for freq_gate_counter (GATE_CYCLES=100, CNT_W=8; second instance with 300)
module tb_freq_gate_counter;

  localparam int G  = 100;
  localparam int G2 = 300;
  localparam int W  = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         edge_pulse = 1'b0;
  logic         start = 1'b0;
  logic         cont = 1'b0;
  logic         freq_ready = 1'b0;
  logic         busy, freq_valid, freq_lost, freq_ovf;
  logic [W-1:0] freq_count;

  logic         start2 = 1'b0;
  logic         freq_ready2 = 1'b0;
  logic         busy2, freq_valid2, freq_lost2, freq_ovf2;
  logic [W-1:0] freq_count2;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  freq_gate_counter #(.GATE_CYCLES(G), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .edge_pulse(edge_pulse), .start(start), .cont(cont),
    .busy(busy), .freq_count(freq_count), .freq_valid(freq_valid),
    .freq_ready(freq_ready), .freq_lost(freq_lost), .freq_ovf(freq_ovf)
  );

  freq_gate_counter #(.GATE_CYCLES(G2), .CNT_W(W)) dut_ovf (
    .clk(clk), .rst(rst), .edge_pulse(edge_pulse), .start(start2), .cont(1'b0),
    .busy(busy2), .freq_count(freq_count2), .freq_valid(freq_valid2),
    .freq_ready(freq_ready2), .freq_lost(freq_lost2), .freq_ovf(freq_ovf2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference timing for the main instance: when a result loads, what busy/valid/lost should be.
  bit m_gate = 0, m_valid = 0, m_lost = 0, m_load = 0;
  int m_t = 0;
  int m_count = 0;

  initial begin
    forever begin
      @(posedge clk);
      m_load = 0;
      if (rst) begin
        m_gate = 0; m_valid = 0; m_lost = 0; m_t = 0; m_count = 0;
      end else begin
        if (!m_gate) begin
          if (start || cont) begin m_gate = 1; m_t = 0; end
        end else if (m_t == G - 1) begin
          m_load = 1; m_gate = cont; m_t = 0;
        end else begin
          m_t++;
        end
        m_lost = m_load && m_valid && !freq_ready;
        if (m_load) m_valid = 1;
        else if (m_valid && freq_ready) m_valid = 0;
      end
      #1;
      if (m_load) begin
        if (exp_q.size() == 0) chk("sb_empty", 0, 1);
        else m_count = exp_q.pop_front();
      end
      chk("busy", busy, m_gate);
      chk("valid", freq_valid, m_valid);
      chk("lost", freq_lost, m_lost);
      chk("count", freq_count, m_count);
      chk("ovf", freq_ovf, 0);
    end
  end

  // pat[0]: start cycle, pat[1..G]: gate cycles, pat[G+1]: cycle after the gate.
  task automatic gate_once(input int mode, input bit ready_last);
    bit pat[0:G+1];
    int n = 0;
    for (int i = 0; i <= G + 1; i++) begin
      case (mode)
        0: pat[i] = (i >= 1 && i <= G && i % 4 == 1);
        1: pat[i] = (i == 0 || i == 1 || i == G || i == G + 1);
        2: pat[i] = 1'($urandom_range(0, 1));
        3: pat[i] = (i >= 1 && i <= G && i % 2 == 0);
        default: pat[i] = 1'b0;
      endcase
      if (i >= 1 && i <= G && pat[i]) n++;
    end
    exp_q.push_back(n);
    for (int i = 0; i <= G + 1; i++) begin
      start      = (i == 0);
      edge_pulse = pat[i];
      freq_ready = ready_last && (i == G);
      step();
    end
    start = 0; edge_pulse = 0; freq_ready = 0;
  endtask

  initial begin
    int n_lost;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_count", freq_count, 0);
    chk("rst_valid", freq_valid, 0);
    chk("rst_lost", freq_lost, 0);
    chk("rst_ovf", freq_ovf, 0);
    chk("rst_valid2", freq_valid2, 0);
    rst = 0;
    repeat (5) step();

    gate_once(0, 0);
    chk("oneshot_count", freq_count, 25);
    chk("oneshot_busy", busy, 0);
    repeat (3) step();
    freq_ready = 1; step(); freq_ready = 0;
    chk("hs_valid_low", freq_valid, 0);
    chk("hs_count_kept", freq_count, 25);

    gate_once(1, 0);
    chk("boundary_count", freq_count, 2);
    gate_once(2, 0);
    gate_once(4, 1);
    chk("load_accept_valid", freq_valid, 1);
    chk("load_accept_count", freq_count, 0);

    freq_ready = 1; step(); freq_ready = 0;
    repeat (3) exp_q.push_back(G);
    n_lost = 0;
    cont = 1; edge_pulse = 1;
    for (int i = 0; i < 320; i++) begin
      if (i == 250) cont = 0;
      step();
      if (freq_lost === 1'b1) n_lost++;
    end
    edge_pulse = 0;
    chk("cont_lost_pulses", n_lost, 2);
    chk("cont_count", freq_count, G);

    start = 1; edge_pulse = 1; step(); start = 0;
    repeat (49) step();
    rst = 1; step(); rst = 0; edge_pulse = 0;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_valid", freq_valid, 0);
    chk("rstmid_count", freq_count, 0);
    repeat (G + 5) step();
    chk("rstmid_no_result", freq_valid, 0);
    gate_once(3, 0);
    chk("after_rst_count", freq_count, 50);

    start2 = 1; edge_pulse = 1; step(); start2 = 0;
    repeat (G2 - 1) step();
    chk("ovf_valid_early", freq_valid2, 0);
    step();
    edge_pulse = 0;
    chk("ovf_valid", freq_valid2, 1);
    chk("ovf_busy", busy2, 0);
`ifdef FREQ_CNT_SAT_EN
    chk("ovf_count", freq_count2, 255);
    chk("ovf_flag", freq_ovf2, 1);
`else
    chk("ovf_count", freq_count2, 44);
    chk("ovf_flag", freq_ovf2, 0);
`endif
    step();
    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
